// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: two-write, NUM_RD-read register file with a per-register
// busy scoreboard. Contents are filled by a sweep FSM after reset.
// Optional feature macro: REGFILE_BYPASS_EN (write-through bypass of rd_data
// and rd_busy). Without it, writes become visible to reads one cycle later.
module regfile_mp_sb #(
   parameter int DW         = 32,
   parameter int DEPTH      = 32,
   parameter int AW         = $clog2(DEPTH),
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 1,
   parameter int INIT_INDEX = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 init_done,
   input  logic                 bubble,
   input  logic                 wr0_en,
   input  logic [AW-1:0]        wr0_addr,
   input  logic [DW-1:0]        wr0_data,
   input  logic                 wr1_en,
   input  logic [AW-1:0]        wr1_addr,
   input  logic [DW-1:0]        wr1_data,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_busy,
   input  logic                 sb_set_en,
   input  logic [AW-1:0]        sb_set_addr
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic ZR_EN = (ZERO_REG != 0);

   state_t           state_r, state_nxt_s;
   logic [AW-1:0]    cnt_r, cnt_nxt_s;
   logic             init_done_r, done_nxt_s;
   logic [DW-1:0]    mem_r [DEPTH];
   logic [DEPTH-1:0] busy_r, busy_nxt_s;
   logic             run_s;
   logic             we0_s, we1_s;
   logic [DW-1:0]    init_val_s;

   assign run_s     = (state_r == ST_RUN);
   assign init_done = init_done_r;

   // Effective write enables: only in RUN, and register 0 is read-only when hardwired
   assign we0_s = run_s && wr0_en && !(ZR_EN && (wr0_addr == {AW{1'b0}}));
   assign we1_s = run_s && wr1_en && !(ZR_EN && (wr1_addr == {AW{1'b0}}));

   assign init_val_s = (INIT_INDEX != 0) ? DW'(cnt_r) : {DW{1'b0}};

   // Sweep FSM next-state: walk every register once, then enter RUN
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_nxt_s  = init_done_r;
      case (state_r)
         ST_INIT: begin
            cnt_nxt_s = cnt_r + {{(AW-1){1'b0}}, 1'b1};
            if (cnt_r == AW'(DEPTH - 1)) begin
               state_nxt_s = ST_RUN;
               done_nxt_s  = 1'b1;
            end else begin
               state_nxt_s = ST_INIT;
               done_nxt_s  = 1'b0;
            end
         end
         ST_RUN: begin
            state_nxt_s = ST_RUN;
            done_nxt_s  = 1'b1;
         end
         default: begin
            state_nxt_s = ST_INIT;
            cnt_nxt_s   = {AW{1'b0}};
            done_nxt_s  = 1'b0;
         end
      endcase
   end

   // Scoreboard next value: writes clear, issue sets (set wins on collision)
   always_comb begin
      busy_nxt_s = busy_r;
      if (run_s) begin
         if (we0_s) begin
            busy_nxt_s[wr0_addr] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
         if (we1_s) begin
            busy_nxt_s[wr1_addr] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
         if (sb_set_en) begin
            busy_nxt_s[sb_set_addr] = 1'b1;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
         if (ZR_EN) begin
            busy_nxt_s[0] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
      end else begin
         busy_nxt_s = busy_r;
      end
   end

   // Control state: FSM, sweep counter, init flag and busy bits
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_INIT;
         cnt_r       <= {AW{1'b0}};
         init_done_r <= 1'b0;
         busy_r      <= {DEPTH{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         init_done_r <= done_nxt_s;
         busy_r      <= busy_nxt_s;
      end
   end

   // Storage array: sweep fill in INIT, port writes in RUN (port 1 last so it wins)
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= init_val_s;
         end
         if (we0_s) begin
            mem_r[wr0_addr] <= wr0_data;
         end
         if (we1_s) begin
            mem_r[wr1_addr] <= wr1_data;
         end
      end
   end

   // Read ports: zero-reg, bubble, optional write-through bypass, then array
   always_comb begin : rd_mux
      logic [AW-1:0] addr_v;
      rd_data = {(NUM_RD*DW){1'b0}};
      rd_busy = {NUM_RD{1'b0}};
      for (int k = 0; k < NUM_RD; k++) begin
         addr_v = rd_addr[k*AW +: AW];
         if (!run_s) begin
            rd_data[k*DW +: DW] = {DW{1'b0}};
            rd_busy[k]          = 1'b0;
         end else begin
`ifdef REGFILE_BYPASS_EN
            rd_busy[k] = busy_r[addr_v] &&
                         !((we0_s && (wr0_addr == addr_v)) || (we1_s && (wr1_addr == addr_v)));
            if (ZR_EN && (addr_v == {AW{1'b0}})) begin
               rd_data[k*DW +: DW] = {DW{1'b0}};
            end else if (bubble) begin
               rd_data[k*DW +: DW] = {DW{1'b0}};
            end else if (we1_s && (wr1_addr == addr_v)) begin
               rd_data[k*DW +: DW] = wr1_data;
            end else if (we0_s && (wr0_addr == addr_v)) begin
               rd_data[k*DW +: DW] = wr0_data;
            end else begin
               rd_data[k*DW +: DW] = mem_r[addr_v];
            end
`else
            rd_busy[k] = busy_r[addr_v];
            if (ZR_EN && (addr_v == {AW{1'b0}})) begin
               rd_data[k*DW +: DW] = {DW{1'b0}};
            end else if (bubble) begin
               rd_data[k*DW +: DW] = {DW{1'b0}};
            end else begin
               rd_data[k*DW +: DW] = mem_r[addr_v];
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (DW=32, DEPTH=32, NUM_RD=2).
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mp_sb;

   localparam int DW = 32;
   localparam int DEPTH = 32;
   localparam int AW = 5;
   localparam int NUM_RD = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 init_done;
   logic                 bubble;
   logic                 wr0_en;
   logic [AW-1:0]        wr0_addr;
   logic [DW-1:0]        wr0_data;
   logic                 wr1_en;
   logic [AW-1:0]        wr1_addr;
   logic [DW-1:0]        wr1_data;
   logic [NUM_RD*AW-1:0] rd_addr;
   logic [NUM_RD*DW-1:0] rd_data;
   logic [NUM_RD-1:0]    rd_busy;
   logic                 sb_set_en;
   logic [AW-1:0]        sb_set_addr;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_mp_sb #(
      .DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1), .INIT_INDEX(1)
   ) dut (
      .clk(clk), .reset(reset), .init_done(init_done), .bubble(bubble),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   task automatic idle();
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
      bubble = 1'b0; sb_set_en = 1'b0; sb_set_addr = '0;
   endtask

   task automatic test_reset();
      int n_low;
      bit sweep_bad;
      idle();
      reset = 1'b1;
      rd_addr = {5'd2, 5'd5};
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (init_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done);
      end
      reset = 1'b0;
      // writes and issue during the sweep must be ignored
      wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h0000_0055;
      sb_set_en = 1'b1; sb_set_addr = 5'd4;
      n_low = 0; sweep_bad = 1'b0;
      #1;
      while (init_done !== 1'b1 && n_low < 100) begin
         if (rd_data !== 64'h0 || rd_busy !== 2'b00) sweep_bad = 1'b1;
         n_low++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (n_low !== 32) begin
         n_fail++; $display("FAIL init_sweep_len: got %0d expected 32", n_low);
      end
      n_tests++;
      if (sweep_bad !== 1'b0) begin
         n_fail++; $display("FAIL sweep_reads_zero: got nonzero rd_data/rd_busy expected 0");
      end
      @(negedge clk); idle();
      rd_addr = {5'd0, 5'd5}; #1;
      n_tests++;
      if (rd_data !== {32'd0, 32'd5}) begin
         n_fail++; $display("FAIL init_values: got %h expected %h", rd_data, {32'd0, 32'd5});
      end
      rd_addr = {5'd4, 5'd2}; #1;
      n_tests++;
      if (rd_data !== {32'd4, 32'd2} || rd_busy !== 2'b00) begin
         n_fail++; $display("FAIL init_ignores_ports: got %h/%b expected %h/00", rd_data, rd_busy, {32'd4, 32'd2});
      end
   endtask

   task automatic test_bypass();
      @(negedge clk); idle();
      wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hDEAD_BEEF;
      rd_addr = {5'd0, 5'd7}; #1;
      n_tests++;
      if (rd_data[31:0] !== (BYP ? 32'hDEAD_BEEF : 32'd7)) begin
         n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rd_data[31:0], (BYP ? 32'hDEAD_BEEF : 32'd7));
      end
      @(negedge clk); idle(); #1;
      n_tests++;
      if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL bypass_next_cycle: got %h expected deadbeef", rd_data[31:0]);
      end
   endtask

   task automatic test_dual_write();
      @(negedge clk); idle();
      wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11;
      wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h22;
      rd_addr = {5'd3, 5'd0}; #1;
      n_tests++;
      if (rd_data[63:32] !== (BYP ? 32'h22 : 32'd3)) begin
         n_fail++; $display("FAIL dual_write_bypass: got %h expected %h", rd_data[63:32], (BYP ? 32'h22 : 32'd3));
      end
      @(negedge clk); idle(); #1;
      n_tests++;
      if (rd_data[63:32] !== 32'h22) begin
         n_fail++; $display("FAIL dual_write_stored: got %h expected 22", rd_data[63:32]);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); idle();
      wr0_en = 1'b1; wr0_addr = 5'd20; wr0_data = 32'hA1;
      wr1_en = 1'b1; wr1_addr = 5'd21; wr1_data = 32'hB1;
      @(negedge clk);
      wr0_addr = 5'd21; wr0_data = 32'hA2;
      wr1_addr = 5'd20; wr1_data = 32'hB2;
      rd_addr = {5'd21, 5'd20}; #1;
      n_tests++;
      if (rd_data !== (BYP ? {32'hA2, 32'hB2} : {32'hB1, 32'hA1})) begin
         n_fail++; $display("FAIL b2b_same_cycle: got %h expected %h", rd_data, (BYP ? {32'hA2, 32'hB2} : {32'hB1, 32'hA1}));
      end
      @(negedge clk); idle(); #1;
      n_tests++;
      if (rd_data !== {32'hA2, 32'hB2}) begin
         n_fail++; $display("FAIL b2b_stored: got %h expected %h", rd_data, {32'hA2, 32'hB2});
      end
   endtask

   task automatic test_scoreboard();
      @(negedge clk); idle();
      sb_set_en = 1'b1; sb_set_addr = 5'd9;
      rd_addr = {5'd0, 5'd9}; #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_before_set: got %b expected 0", rd_busy[0]);
      end
      @(negedge clk);
      n_tests++;
      if (rd_busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL sb_set: got %b expected 1", rd_busy[0]);
      end
      wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
      @(negedge clk); idle(); #1;
      n_tests++;
      if (rd_busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL sb_set_wins: got %b expected 1", rd_busy[0]);
      end
      wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h9A; #1;
      n_tests++;
      if (rd_busy[0] !== (BYP ? 1'b0 : 1'b1)) begin
         n_fail++; $display("FAIL sb_clear_bypass: got %b expected %b", rd_busy[0], (BYP ? 1'b0 : 1'b1));
      end
      @(negedge clk); idle(); #1;
      n_tests++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h9A) begin
         n_fail++; $display("FAIL sb_cleared: got %b/%h expected 0/0000009a", rd_busy[0], rd_data[31:0]);
      end
   endtask

   task automatic test_zero_bubble();
      @(negedge clk); idle();
      wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFF;
      sb_set_en = 1'b1; sb_set_addr = 5'd0;
      rd_addr = {5'd0, 5'd0}; #1;
      n_tests++;
      if (rd_data !== 64'h0) begin
         n_fail++; $display("FAIL zero_reg_bypass: got %h expected 0", rd_data);
      end
      @(negedge clk); idle();
      sb_set_en = 1'b1; sb_set_addr = 5'd5; #1;
      n_tests++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
         n_fail++; $display("FAIL zero_reg_stored: got %h/%b expected 0/00", rd_data, rd_busy);
      end
      @(negedge clk); idle();
      bubble = 1'b1;
      rd_addr = {5'd7, 5'd5}; #1;
      n_tests++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b01) begin
         n_fail++; $display("FAIL bubble: got %h/%b expected 0/01", rd_data, rd_busy);
      end
      bubble = 1'b0; #1;
      n_tests++;
      if (rd_data !== {32'hDEAD_BEEF, 32'd5} || rd_busy !== 2'b01) begin
         n_fail++; $display("FAIL bubble_off: got %h/%b expected %h/01", rd_data, rd_busy, {32'hDEAD_BEEF, 32'd5});
      end
   endtask

   task automatic test_reset_mid();
      int n_low;
      @(negedge clk); idle();
      wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'hAB;
      @(negedge clk); idle();
      sb_set_en = 1'b1; sb_set_addr = 5'd12;
      @(negedge clk); idle();
      rd_addr = {5'd7, 5'd12}; #1;
      n_tests++;
      if (rd_data[31:0] !== 32'hAB || rd_busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_state: got %h/%b expected 000000ab/1", rd_data[31:0], rd_busy[0]);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (rd_busy !== 2'b00 || init_done !== 1'b0) begin
         n_fail++; $display("FAIL reset_clears_busy: got %b/%b expected 00/0", rd_busy, init_done);
      end
      // release, let the sweep run partway, then reset again mid-sweep
      @(negedge clk); reset = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      n_low = 0; #1;
      while (init_done !== 1'b1 && n_low < 100) begin
         n_low++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (n_low !== 32) begin
         n_fail++; $display("FAIL mid_sweep_reset_len: got %0d expected 32", n_low);
      end
      @(negedge clk); #1;
      n_tests++;
      if (rd_data !== {32'd7, 32'd12} || rd_busy !== 2'b00) begin
         n_fail++; $display("FAIL post_reset_values: got %h/%b expected %h/00", rd_data, rd_busy, {32'd7, 32'd12});
      end
   endtask

   // Test sequence
   initial begin
      idle();
      reset = 1'b1;
      rd_addr = '0;
      test_reset();
      test_bypass();
      test_dual_write();
      test_back_to_back();
      test_scoreboard();
      test_zero_bubble();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
